// File: rtl/scpu_mem_loader_pkg.sv
// Shared definitions for the serial program loader: FSM states and frame header fields.
package scpu_mem_loader_pkg;

    localparam int unsigned ADDR_W_DEF = 9;
    localparam int unsigned DATA_W_DEF = 8;

    // HDR0 carries only the address MSB in bit 0; the remaining bits are reserved and must be 0
    localparam logic [7:0]  HDR0_RSV_MASK      = 8'hFE;
    localparam int unsigned HDR0_ADDR_HI_BIT   = 0;
    localparam bit          LEN_ZERO_MEANS_MAX = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HDR0,
        ST_HDR1,
        ST_LEN,
        ST_DATA,
        ST_START,
        ST_DONE,
        ST_ERR
    } state_t;

    function automatic logic is_session(input state_t s);
        return (s == ST_HDR0) || (s == ST_HDR1) || (s == ST_LEN) || (s == ST_DATA);
    endfunction

endpackage

// File: rtl/scpu_mem_loader_if.sv
// Memory write port shared with the CPU: the loader drives it, the address/data mux consumes it.
interface scpu_mem_loader_if #(
    parameter int unsigned ADDR_W = 9,
    parameter int unsigned DATA_W = 8
);
    logic              mem_sel;
    logic [ADDR_W-1:0] m_addr;
    logic              m_we;
    logic [DATA_W-1:0] m_wdata;

    modport master (
        output mem_sel,
        output m_addr,
        output m_we,
        output m_wdata
    );

    modport slave (
        input mem_sel,
        input m_addr,
        input m_we,
        input m_wdata
    );
endinterface

// File: rtl/scpu_ser_byte_rx.sv
// Serial-to-byte assembler, MSB first; byte_valid is combinational on the cycle of the final bit.
module scpu_ser_byte_rx #(
    parameter int unsigned DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              en,
    input  logic              sin_valid,
    input  logic              sin_bit,
    output logic              byte_valid,
    output logic [DATA_W-1:0] byte_data
);
    localparam int unsigned CNT_W = $clog2(DATA_W);

    // The oldest bit is shifted out exactly when the byte completes, so only DATA_W-1 bits are kept
    logic [DATA_W-2:0] sr;
    logic [CNT_W-1:0]  bit_cnt;
    logic              shift;

    assign shift      = en && sin_valid;
    assign byte_valid = shift && (bit_cnt == CNT_W'(DATA_W - 1));
    assign byte_data  = {sr, sin_bit};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sr      <= '0;
            bit_cnt <= '0;
        end else if (clr) begin
            sr      <= '0;
            bit_cnt <= '0;
        end else if (shift) begin
            sr      <= {sr[DATA_W-3:0], sin_bit};
            bit_cnt <= bit_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/scpu_mem_loader.sv
// Serial program loader: parses a 3-byte header, writes the payload into CPU memory, then releases the CPU.
module scpu_mem_loader
    import scpu_mem_loader_pkg::*;
#(
    parameter int unsigned ADDR_W     = ADDR_W_DEF,
    parameter int unsigned DATA_W     = DATA_W_DEF,
    parameter bit          AUTO_START = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load_en,
    input  logic sin_valid,
    input  logic sin_bit,
    output logic busy,
    output logic done,
    output logic err,
    output logic cpu_enable,
    output logic cpu_start,
    scpu_mem_loader_if.master mem
);
    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W:0]   remain_q, remain_d;
    logic              loaded_q, loaded_d;
    logic              err_q, err_d;
    logic              load_en_q;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] waddr_q, waddr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;

    logic              in_session;
    logic              rx_clr;
    logic              byte_valid;
    logic [DATA_W-1:0] byte_data;

    assign in_session = is_session(state_q);

    scpu_ser_byte_rx #(.DATA_W(DATA_W)) u_rx (
        .clk        (clk),
        .rst_n      (rst_n),
        .clr        (rx_clr),
        .en         (in_session),
        .sin_valid  (sin_valid),
        .sin_bit    (sin_bit),
        .byte_valid (byte_valid),
        .byte_data  (byte_data)
    );

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        remain_d = remain_q;
        loaded_d = loaded_q;
        err_d    = err_q;
        we_d     = 1'b0;
        waddr_d  = waddr_q;
        wdata_d  = wdata_q;
        rx_clr   = 1'b0;

        if (in_session && !load_en) begin
            // Abort: a byte completing in this cycle is dropped; an already registered write has finished
            state_d = ST_IDLE;
            err_d   = 1'b1;
            rx_clr  = 1'b1;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (load_en && !load_en_q) begin
                        state_d  = ST_HDR0;
                        err_d    = 1'b0;
                        loaded_d = 1'b0;
                        rx_clr   = 1'b1;
                    end
                end
                ST_HDR0: begin
                    if (byte_valid) begin
                        if ((byte_data & DATA_W'(HDR0_RSV_MASK)) != '0) begin
                            state_d = ST_ERR;
                            err_d   = 1'b1;
                        end else begin
                            addr_d           = '0;
                            addr_d[ADDR_W-1] = byte_data[HDR0_ADDR_HI_BIT];
                            state_d          = ST_HDR1;
                        end
                    end
                end
                ST_HDR1: begin
                    if (byte_valid) begin
                        addr_d[ADDR_W-2:0] = byte_data[ADDR_W-2:0];
                        state_d            = ST_LEN;
                    end
                end
                ST_LEN: begin
                    if (byte_valid) begin
                        if (LEN_ZERO_MEANS_MAX && (byte_data == '0))
                            remain_d = {1'b1, {DATA_W{1'b0}}};
                        else
                            remain_d = {1'b0, byte_data};
                        state_d = ST_DATA;
                    end
                end
                ST_DATA: begin
                    // remain_q reaches 0 during the final write cycle, which keeps mem_sel high through it
                    if (remain_q == '0) begin
                        state_d  = ST_START;
                        loaded_d = 1'b1;
                    end else if (byte_valid) begin
                        we_d     = 1'b1;
                        waddr_d  = addr_q;
                        wdata_d  = byte_data;
                        addr_d   = addr_q + 1'b1;
                        remain_d = remain_q - 1'b1;
                    end
                end
                ST_START: state_d = ST_DONE;
                ST_DONE, ST_ERR: begin
                    if (!load_en)
                        state_d = ST_IDLE;
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            addr_q    <= '0;
            remain_q  <= '0;
            loaded_q  <= 1'b0;
            err_q     <= 1'b0;
            load_en_q <= 1'b0;
            we_q      <= 1'b0;
            waddr_q   <= '0;
            wdata_q   <= '0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            remain_q  <= remain_d;
            loaded_q  <= loaded_d;
            err_q     <= err_d;
            load_en_q <= load_en;
            we_q      <= we_d;
            waddr_q   <= waddr_d;
            wdata_q   <= wdata_d;
        end
    end

    assign busy        = in_session;
    assign done        = (state_q == ST_DONE);
    assign err         = err_q;
    assign cpu_enable  = loaded_q && ((state_q == ST_IDLE) || (state_q == ST_START) || (state_q == ST_DONE));
    assign cpu_start   = AUTO_START && (state_q == ST_START);

    assign mem.mem_sel = in_session;
    assign mem.m_we    = we_q;
    assign mem.m_addr  = waddr_q;
    assign mem.m_wdata = wdata_q;

endmodule

// File: tb/tb_scpu_mem_loader.sv
// Directed bench for scpu_mem_loader: framing, wrap, 256-byte load, errors, abort, reset and AUTO_START=0.
module tb_scpu_mem_loader;

    logic clk       = 1'b0;
    logic rst_n     = 1'b0;
    logic load_en   = 1'b0;
    logic sin_valid = 1'b0;
    logic sin_bit   = 1'b0;

    logic busy, done, err, cpu_enable, cpu_start;
    logic busy_na, done_na, err_na, cpu_enable_na, cpu_start_na;

    scpu_mem_loader_if #(.ADDR_W(9), .DATA_W(8)) bus ();
    scpu_mem_loader_if #(.ADDR_W(9), .DATA_W(8)) bus_na ();

    scpu_mem_loader #(.ADDR_W(9), .DATA_W(8), .AUTO_START(1'b1)) u_dut (
        .clk(clk), .rst_n(rst_n), .load_en(load_en), .sin_valid(sin_valid), .sin_bit(sin_bit),
        .busy(busy), .done(done), .err(err), .cpu_enable(cpu_enable), .cpu_start(cpu_start),
        .mem(bus)
    );

    scpu_mem_loader #(.ADDR_W(9), .DATA_W(8), .AUTO_START(1'b0)) u_dut_na (
        .clk(clk), .rst_n(rst_n), .load_en(load_en), .sin_valid(sin_valid), .sin_bit(sin_bit),
        .busy(busy_na), .done(done_na), .err(err_na), .cpu_enable(cpu_enable_na), .cpu_start(cpu_start_na),
        .mem(bus_na)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    int unsigned cyc = 0;
    int unsigned start_cnt = 0;
    int unsigned start_cyc = 0;
    int unsigned na_start_cnt = 0;
    int unsigned nosel_cnt = 0;
    int unsigned na_nosel_cnt = 0;

    logic [8:0]  wr_addr_q [$];
    logic [7:0]  wr_data_q [$];
    int unsigned wr_cyc_q [$];
    int unsigned byte_edge [$];
    logic [7:0]  dbuf [256];

    // Write/start log: cyc seen here is the index of the edge that opened the sampled cycle
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (bus.m_we) begin
            wr_addr_q.push_back(bus.m_addr);
            wr_data_q.push_back(bus.m_wdata);
            wr_cyc_q.push_back(cyc);
            if (!bus.mem_sel) nosel_cnt <= nosel_cnt + 1;
        end
        if (bus_na.m_we && !bus_na.mem_sel) na_nosel_cnt <= na_nosel_cnt + 1;
        if (cpu_start) begin
            start_cnt <= start_cnt + 1;
            start_cyc <= cyc;
        end
        if (cpu_start_na) na_start_cnt <= na_start_cnt + 1;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    task automatic send_byte(input logic [7:0] b, input bit gaps);
        for (int i = 7; i >= 0; i--) begin
            if (gaps) begin
                int unsigned g;
                g = $urandom_range(1, 3);
                sin_valid = 1'b0;
                repeat (g) @(negedge clk);
            end
            sin_valid = 1'b1;
            sin_bit   = b[i];
            @(negedge clk);
        end
        byte_edge.push_back(cyc);
    endtask

    task automatic send_frame(input logic [7:0] h0, input logic [7:0] h1, input logic [7:0] ln,
                              input int n, input bit gaps);
        byte_edge.delete();
        send_byte(h0, gaps);
        send_byte(h1, gaps);
        send_byte(ln, gaps);
        for (int i = 0; i < n; i++) send_byte(dbuf[i], gaps);
        sin_valid = 1'b0;
    endtask

    task automatic session_open();
        @(negedge clk);
        load_en = 1'b1;
        @(negedge clk);
    endtask

    task automatic session_close();
        load_en = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        checks++; if ({busy, done, err, cpu_enable, cpu_start, bus.mem_sel, bus.m_we} !== 7'b0) begin
            errors++; $display("FAIL reset_ctl: got %b exp 0000000", {busy, done, err, cpu_enable, cpu_start, bus.mem_sel, bus.m_we}); end
        checks++; if (bus.m_addr !== 9'd0 || bus.m_wdata !== 8'd0) begin
            errors++; $display("FAIL reset_bus: got %h/%h exp 000/00", bus.m_addr, bus.m_wdata); end
        checks++; if ({busy_na, done_na, err_na, cpu_enable_na, cpu_start_na, bus_na.m_we} !== 6'b0) begin
            errors++; $display("FAIL reset_na: got %b exp 000000", {busy_na, done_na, err_na, cpu_enable_na, cpu_start_na, bus_na.m_we}); end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        checks++; if ({busy, done, err, cpu_enable, bus.mem_sel} !== 5'b0) begin
            errors++; $display("FAIL reset_idle: got %b exp 00000", {busy, done, err, cpu_enable, bus.mem_sel}); end
    endtask

    task automatic test_basic();
        int unsigned wb, sb;
        wb = wr_addr_q.size(); sb = start_cnt;
        session_open();
        checks++; if ({busy, bus.mem_sel, cpu_enable, err} !== 4'b1100) begin
            errors++; $display("FAIL basic_open: got %b exp 1100", {busy, bus.mem_sel, cpu_enable, err}); end
        dbuf[0] = 8'hA1; dbuf[1] = 8'hB2; dbuf[2] = 8'hC3;
        send_frame(8'h00, 8'h05, 8'h03, 3, 1'b0);
        checks++; if ({bus.m_we, bus.mem_sel, busy} !== 3'b111) begin
            errors++; $display("FAIL basic_lastwr: got %b exp 111", {bus.m_we, bus.mem_sel, busy}); end
        @(negedge clk);
        checks++; if ({cpu_start, cpu_enable, busy, bus.mem_sel, done} !== 5'b11000) begin
            errors++; $display("FAIL basic_start: got %b exp 11000", {cpu_start, cpu_enable, busy, bus.mem_sel, done}); end
        @(negedge clk);
        checks++; if ({cpu_start, cpu_enable, done} !== 3'b011) begin
            errors++; $display("FAIL basic_done: got %b exp 011", {cpu_start, cpu_enable, done}); end
        checks++; if (wr_addr_q.size() - wb !== 3) begin
            errors++; $display("FAIL basic_nwr: got %0d exp 3", wr_addr_q.size() - wb); end
        for (int i = 0; i < 3 && wb + i < wr_addr_q.size(); i++) begin
            checks++; if (wr_addr_q[wb+i] !== 9'(5 + i) || wr_data_q[wb+i] !== dbuf[i] || wr_cyc_q[wb+i] !== byte_edge[3+i]) begin
                errors++; $display("FAIL basic_wr%0d: got %0d/%h@%0d exp %0d/%h@%0d", i, wr_addr_q[wb+i], wr_data_q[wb+i],
                                   wr_cyc_q[wb+i], 5 + i, dbuf[i], byte_edge[3+i]); end
        end
        checks++; if (start_cnt - sb !== 1 || start_cyc !== byte_edge[5] + 1) begin
            errors++; $display("FAIL basic_startcyc: got n=%0d@%0d exp n=1@%0d", start_cnt - sb, start_cyc, byte_edge[5] + 1); end
        session_close();
        checks++; if ({done, cpu_enable, busy, err} !== 4'b0100) begin
            errors++; $display("FAIL basic_idle: got %b exp 0100", {done, cpu_enable, busy, err}); end
    endtask

    task automatic test_wrap();
        logic [8:0] exp_a [2];
        exp_a[0] = 9'd511; exp_a[1] = 9'd0;
        for (int pass = 0; pass < 2; pass++) begin
            int unsigned wb;
            wb = wr_addr_q.size();
            session_open();
            dbuf[0] = 8'h11; dbuf[1] = 8'h22;
            send_frame(8'h01, 8'hFF, 8'h02, 2, pass == 1);
            repeat (2) @(negedge clk);
            checks++; if (wr_addr_q.size() - wb !== 2 || done !== 1'b1) begin
                errors++; $display("FAIL wrap%0d_count: got n=%0d done=%b exp n=2 done=1", pass, wr_addr_q.size() - wb, done); end
            for (int i = 0; i < 2 && wb + i < wr_addr_q.size(); i++) begin
                checks++; if (wr_addr_q[wb+i] !== exp_a[i] || wr_data_q[wb+i] !== dbuf[i] || wr_cyc_q[wb+i] !== byte_edge[3+i]) begin
                    errors++; $display("FAIL wrap%0d_wr%0d: got %0d/%h@%0d exp %0d/%h@%0d", pass, i, wr_addr_q[wb+i],
                                       wr_data_q[wb+i], wr_cyc_q[wb+i], exp_a[i], dbuf[i], byte_edge[3+i]); end
            end
            session_close();
        end
    endtask

    task automatic test_full256();
        int unsigned wb, sb, bad;
        wb = wr_addr_q.size(); sb = start_cnt; bad = 0;
        for (int i = 0; i < 256; i++) dbuf[i] = 8'(i);
        session_open();
        send_frame(8'h00, 8'h00, 8'h00, 256, 1'b0);
        repeat (2) @(negedge clk);
        checks++; if (wr_addr_q.size() - wb !== 256) begin
            errors++; $display("FAIL full_nwr: got %0d exp 256", wr_addr_q.size() - wb); end
        for (int i = 0; i < 256 && wb + i < wr_addr_q.size(); i++) begin
            checks++; if (wr_addr_q[wb+i] !== 9'(i) || wr_data_q[wb+i] !== 8'(i)) begin
                errors++; $display("FAIL full_wr%0d: got %0d/%h exp %0d/%h", i, wr_addr_q[wb+i], wr_data_q[wb+i], i, 8'(i)); end
        end
        checks++; if (start_cnt - sb !== 1 || start_cyc !== byte_edge[258] + 1 || done !== 1'b1) begin
            errors++; $display("FAIL full_start: got n=%0d@%0d done=%b exp n=1@%0d done=1", start_cnt - sb, start_cyc, done,
                               byte_edge[258] + 1); end
        session_close();
    endtask

    task automatic test_bad_header();
        int unsigned wb;
        wb = wr_addr_q.size();
        session_open();
        byte_edge.delete();
        send_byte(8'h02, 1'b0);
        sin_valid = 1'b0;
        checks++; if ({err, bus.mem_sel, busy, cpu_enable} !== 4'b1000) begin
            errors++; $display("FAIL badhdr_err: got %b exp 1000", {err, bus.mem_sel, busy, cpu_enable}); end
        send_byte(8'h05, 1'b0);
        send_byte(8'h01, 1'b0);
        send_byte(8'h3C, 1'b0);
        sin_valid = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (wr_addr_q.size() - wb !== 0 || {err, busy, bus.mem_sel} !== 3'b100) begin
            errors++; $display("FAIL badhdr_ignore: got n=%0d st=%b exp n=0 st=100", wr_addr_q.size() - wb, {err, busy, bus.mem_sel}); end
        session_close();
        checks++; if ({err, cpu_enable, done} !== 3'b100) begin
            errors++; $display("FAIL badhdr_sticky: got %b exp 100", {err, cpu_enable, done}); end
        session_open();
        checks++; if ({err, busy} !== 2'b01) begin
            errors++; $display("FAIL badhdr_clear: got %b exp 01", {err, busy}); end
        dbuf[0] = 8'h5A;
        send_frame(8'h00, 8'h10, 8'h01, 1, 1'b0);
        repeat (2) @(negedge clk);
        checks++; if (wr_addr_q.size() - wb !== 1 || wr_addr_q[$] !== 9'h010 || wr_data_q[$] !== 8'h5A || done !== 1'b1) begin
            errors++; $display("FAIL badhdr_reload: got n=%0d %h/%h done=%b exp n=1 010/5a done=1", wr_addr_q.size() - wb,
                               wr_addr_q[$], wr_data_q[$], done); end
        session_close();
    endtask

    task automatic test_abort();
        int unsigned wb, sb;
        logic [7:0] b;
        wb = wr_addr_q.size(); sb = start_cnt;
        session_open();
        byte_edge.delete();
        send_byte(8'h00, 1'b0); send_byte(8'h20, 1'b0); send_byte(8'h03, 1'b0); send_byte(8'h3C, 1'b0);
        b = 8'hC3;
        for (int i = 7; i >= 4; i--) begin
            sin_valid = 1'b1; sin_bit = b[i];
            @(negedge clk);
        end
        sin_valid = 1'b0;
        load_en = 1'b0;
        @(negedge clk);
        checks++; if ({err, bus.mem_sel, busy, cpu_enable, cpu_start} !== 5'b10000) begin
            errors++; $display("FAIL abort_state: got %b exp 10000", {err, bus.mem_sel, busy, cpu_enable, cpu_start}); end
        repeat (3) @(negedge clk);
        checks++; if (wr_addr_q.size() - wb !== 1 || wr_addr_q[$] !== 9'h020 || wr_data_q[$] !== 8'h3C || start_cnt - sb !== 0) begin
            errors++; $display("FAIL abort_writes: got n=%0d %h/%h starts=%0d exp n=1 020/3c starts=0", wr_addr_q.size() - wb,
                               wr_addr_q[$], wr_data_q[$], start_cnt - sb); end

        // load_en falls during a registered write cycle: that write must still land
        wb = wr_addr_q.size();
        session_open();
        send_byte(8'h00, 1'b0); send_byte(8'h30, 1'b0); send_byte(8'h02, 1'b0); send_byte(8'h77, 1'b0);
        sin_valid = 1'b0;
        load_en = 1'b0;
        checks++; if ({bus.m_we, bus.mem_sel} !== 2'b11 || bus.m_addr !== 9'h030 || bus.m_wdata !== 8'h77) begin
            errors++; $display("FAIL abortwr_bus: got we/sel=%b %h/%h exp 11 030/77", {bus.m_we, bus.mem_sel}, bus.m_addr, bus.m_wdata); end
        @(negedge clk);
        checks++; if ({err, bus.mem_sel, busy, cpu_enable, bus.m_we} !== 5'b10000) begin
            errors++; $display("FAIL abortwr_state: got %b exp 10000", {err, bus.mem_sel, busy, cpu_enable, bus.m_we}); end
        repeat (3) @(negedge clk);
        checks++; if (wr_addr_q.size() - wb !== 1 || start_cnt - sb !== 0 || cpu_enable !== 1'b0) begin
            errors++; $display("FAIL abortwr_count: got n=%0d starts=%0d en=%b exp n=1 starts=0 en=0", wr_addr_q.size() - wb,
                               start_cnt - sb, cpu_enable); end
    endtask

    task automatic test_reset_mid();
        int unsigned wb;
        wb = wr_addr_q.size();
        session_open();
        byte_edge.delete();
        send_byte(8'h00, 1'b0); send_byte(8'h40, 1'b0); send_byte(8'h04, 1'b0);
        send_byte(8'h12, 1'b0); send_byte(8'h34, 1'b0);
        sin_valid = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        checks++; if ({busy, done, err, cpu_enable, cpu_start, bus.mem_sel, bus.m_we} !== 7'b0 || bus.m_addr !== 9'd0 || bus.m_wdata !== 8'd0) begin
            errors++; $display("FAIL rstmid_outs: got %b %h/%h exp 0000000 000/00",
                               {busy, done, err, cpu_enable, cpu_start, bus.mem_sel, bus.m_we}, bus.m_addr, bus.m_wdata); end
        load_en = 1'b0;
        @(negedge clk);
        checks++; if (wr_addr_q.size() - wb !== 1 || wr_data_q[$] !== 8'h12) begin
            errors++; $display("FAIL rstmid_partial: got n=%0d last=%h exp n=1 last=12", wr_addr_q.size() - wb, wr_data_q[$]); end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        wb = wr_addr_q.size();
        session_open();
        dbuf[0] = 8'h99; dbuf[1] = 8'h66;
        send_frame(8'h00, 8'h40, 8'h02, 2, 1'b0);
        repeat (2) @(negedge clk);
        checks++; if (wr_addr_q.size() - wb !== 2 || {done, cpu_enable} !== 2'b11) begin
            errors++; $display("FAIL rstmid_reload: got n=%0d st=%b exp n=2 st=11", wr_addr_q.size() - wb, {done, cpu_enable}); end
        if (wr_addr_q.size() - wb == 2) begin
            checks++; if (wr_addr_q[wb] !== 9'h040 || wr_data_q[wb] !== 8'h99 || wr_addr_q[wb+1] !== 9'h041 || wr_data_q[wb+1] !== 8'h66) begin
                errors++; $display("FAIL rstmid_data: got %h/%h %h/%h exp 040/99 041/66", wr_addr_q[wb], wr_data_q[wb],
                                   wr_addr_q[wb+1], wr_data_q[wb+1]); end
        end
        session_close();
    endtask

    task automatic test_no_autostart();
        session_open();
        dbuf[0] = 8'hE7;
        send_frame(8'h00, 8'h08, 8'h01, 1, 1'b0);
        checks++; if (bus_na.m_we !== 1'b1 || bus_na.m_addr !== 9'h008 || bus_na.m_wdata !== 8'hE7) begin
            errors++; $display("FAIL noauto_wr: got %b %h/%h exp 1 008/e7", bus_na.m_we, bus_na.m_addr, bus_na.m_wdata); end
        @(negedge clk);
        checks++; if ({cpu_start_na, cpu_enable_na, busy_na, cpu_start} !== 4'b0101) begin
            errors++; $display("FAIL noauto_start: got %b exp 0101", {cpu_start_na, cpu_enable_na, busy_na, cpu_start}); end
        @(negedge clk);
        checks++; if ({done_na, cpu_enable_na} !== 2'b11) begin
            errors++; $display("FAIL noauto_done: got %b exp 11", {done_na, cpu_enable_na}); end
        session_close();
        checks++; if ({cpu_enable_na, done_na, na_start_cnt} !== {2'b10, 32'd0}) begin
            errors++; $display("FAIL noauto_idle: got en=%b done=%b starts=%0d exp en=1 done=0 starts=0",
                               cpu_enable_na, done_na, na_start_cnt); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_wrap();
        test_full256();
        test_bad_header();
        test_abort();
        test_reset_mid();
        test_no_autostart();
        checks++; if (nosel_cnt !== 0 || na_nosel_cnt !== 0) begin
            errors++; $display("FAIL we_without_sel: got %0d/%0d exp 0/0", nosel_cnt, na_nosel_cnt); end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
